// File: rtl/cim_cmd_sequencer.sv
// rtl/cim_cmd_sequencer.sv - command sequencer driving the CIM macro through write, compute and readout phases
module cim_cmd_sequencer #(
    parameter int ADDR_W   = 9,
    parameter int NBITS    = 8,
    parameter int WAIT_CYC = 4,
    parameter int NREAD    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_epol,
    input  logic              cmd_eact,
    output logic              wen,
    output logic              wbuf,
    output logic              cal,
    output logic [ADDR_W-1:0] a_in,
    output logic              read,
    output logic [3:0]        cim_a,
    output logic              epol,
    output logic              eact,
    output logic              rd_strobe,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W  = (NBITS > 1)    ? $clog2(NBITS)    : 1;
    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int RD_W   = (NREAD > 1)    ? $clog2(NREAD)    : 1;

    typedef enum logic [3:0] {
        IDLE, WRT, WRTBUF, SET, COMP, INBIT, WAIT, READ, DONE
    } state_t;

    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RD_W-1:0]   rd_cnt;

    assign cmd_ready = (state == IDLE) && !rst;

    // Outputs are assigned alongside the state they belong to, so each pin
    // reflects the state being entered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            rd_cnt    <= '0;
            wen       <= 1'b0;
            wbuf      <= 1'b0;
            cal       <= 1'b0;
            a_in      <= '0;
            read      <= 1'b0;
            cim_a     <= '0;
            epol      <= 1'b0;
            eact      <= 1'b0;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wen       <= 1'b0;
            wbuf      <= 1'b0;
            cal       <= 1'b0;
            read      <= 1'b0;
            rd_strobe <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00: begin
                                state <= WRT;
                                wen   <= 1'b1;
                                a_in  <= cmd_addr;
                                busy  <= 1'b1;
                            end
                            2'b01: begin
                                state <= WRTBUF;
                                wen   <= 1'b1;
                                wbuf  <= 1'b1;
                                a_in  <= cmd_addr;
                                busy  <= 1'b1;
                            end
                            2'b10: begin
                                state <= SET;
                                cal   <= 1'b1;
                                a_in  <= cmd_addr;
                                epol  <= cmd_epol;
                                eact  <= cmd_eact;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                WRT, WRTBUF: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                SET: begin
                    state   <= COMP;
                    cal     <= 1'b1;
                    bit_cnt <= '0;
                end
                COMP: begin
                    state <= INBIT;
                    cal   <= 1'b1;
                end
                INBIT: begin
                    if (bit_cnt == BIT_W'(NBITS - 1)) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state   <= COMP;
                        cal     <= 1'b1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_W'(WAIT_CYC - 1)) begin
                        state     <= READ;
                        read      <= 1'b1;
                        rd_strobe <= 1'b1;
                        rd_cnt    <= '0;
                        cim_a     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                READ: begin
                    if (rd_cnt == RD_W'(NREAD - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        cim_a <= '0;
                    end else begin
                        read      <= 1'b1;
                        rd_strobe <= 1'b1;
                        rd_cnt    <= rd_cnt + RD_W'(1);
                        cim_a     <= 4'(rd_cnt + RD_W'(1));
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    a_in  <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    a_in  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_cmd_sequencer.sv
// tb/tb_cim_cmd_sequencer.sv - scoreboard bench for cim_cmd_sequencer
module tb_cim_cmd_sequencer;

    localparam int ADDR_W   = 9;
    localparam int NBITS    = 8;
    localparam int WAIT_CYC = 4;
    localparam int NREAD    = 16;
    localparam int RD_OFS   = 2 + 2 * NBITS + WAIT_CYC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              cmd_epol = 1'b0;
    logic              cmd_eact = 1'b0;
    logic              wen, wbuf, cal, read, epol, eact, rd_strobe, busy, done;
    logic [ADDR_W-1:0] a_in;
    logic [3:0]        cim_a;

    cim_cmd_sequencer #(
        .ADDR_W(ADDR_W), .NBITS(NBITS), .WAIT_CYC(WAIT_CYC), .NREAD(NREAD)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_epol(cmd_epol), .cmd_eact(cmd_eact),
        .wen(wen), .wbuf(wbuf), .cal(cal), .a_in(a_in), .read(read), .cim_a(cim_a),
        .epol(epol), .eact(eact), .rd_strobe(rd_strobe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cycle;
        logic        wbuf;
        logic [8:0]  addr;
        logic [3:0]  col;
        logic        epol;
        logic        eact;
        int          calrun;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    logic m_epol = 1'b0;
    logic m_eact = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void push_ev(input int kind, input int cycle, input logic wb,
                                    input logic [8:0] addr, input logic [3:0] col,
                                    input logic ep, input logic ea, input int calrun);
        ev_t e;
        e.kind = kind; e.cycle = cycle; e.wbuf = wb; e.addr = addr; e.col = col;
        e.epol = ep; e.eact = ea; e.calrun = calrun;
        exp_q.push_back(e);
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every pin event.
    int   cal_len  = 0;
    logic prev_cal = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (cal) cal_len = prev_cal ? cal_len + 1 : 1;
        prev_cal = cal;
        chk("invariants", longint'(!(wen && cal) && !(wbuf && !wen) &&
                                   !(read && (wen || cal || !rd_strobe || !busy))), 1);
        if (wen || rd_strobe || done) begin
            kind = wen ? 0 : (rd_strobe ? 1 : 2);
            if (exp_q.size() == 0) begin
                chk("spurious_event_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cycle);
                chk("a_in", a_in, e.addr);
                if (kind == 0) chk("wbuf", wbuf, e.wbuf);
                if (kind == 1) begin
                    chk("cim_a", cim_a, e.col);
                    chk("read_with_strobe", read, 1);
                end
                if (kind == 2) begin
                    chk("done_epol", epol, e.epol);
                    chk("done_eact", eact, e.eact);
                    if (e.calrun >= 0) chk("cal_run_len", cal_len, e.calrun);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [8:0] addr, input logic ep,
                        input logic ea, input int nrd, input bit with_done, output int t);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_epol = ep; cmd_eact = ea;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            if (op == 2'b00 || op == 2'b01) begin
                push_ev(0, t + 1, op[0], addr, 4'd0, 1'b0, 1'b0, -1);
                push_ev(2, t + 2, 1'b0, addr, 4'd0, m_epol, m_eact, -1);
            end else if (op == 2'b10) begin
                m_epol = ep; m_eact = ea;
                for (int i = 0; i < nrd; i++)
                    push_ev(1, t + RD_OFS + i, 1'b0, addr, 4'(i), 1'b0, 1'b0, -1);
                if (with_done)
                    push_ev(2, t + RD_OFS + NREAD, 1'b0, addr, 4'd0, ep, ea, 2 * NBITS + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        chk("idle_timeout", cmd_ready, 1);
    endtask

    function automatic longint all_outs();
        return longint'({wen, wbuf, cal, a_in, read, cim_a, epol, eact, rd_strobe, busy, done});
    endfunction

    initial begin
        int t, t1, t2, t3;
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        chk("reset_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", all_outs(), 0);
        chk("post_reset_ready", cmd_ready, 1);

        send(2'b00, 9'h1A5, 1'b0, 1'b0, 0, 1'b1, t);
        cmd_valid = 1'b0;
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_ready_t2", cmd_ready, 0);
        @(negedge clk);
        chk("wr_ready_t3", cmd_ready, 1);

        send(2'b01, 9'h003, 1'b0, 1'b0, 0, 1'b1, t);
        cmd_valid = 1'b0;
        wait_idle();

        send(2'b10, 9'h010, 1'b1, 1'b0, NREAD, 1'b1, t);
        cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("epol_held", epol, 1);
        chk("eact_held", eact, 0);

        send(2'b10, 9'h0F0, 1'b0, 1'b1, NREAD, 1'b1, t1);
        send(2'b11, 9'h1FF, 1'b1, 1'b1, 0, 1'b0, t2);
        send(2'b00, 9'h055, 1'b0, 1'b0, 0, 1'b1, t3);
        cmd_valid = 1'b0;
        chk("b2b_reserved_accept", t2, t1 + 3 + RD_OFS + NREAD - 2);
        chk("b2b_write_accept", t3, t2 + 1);
        wait_idle();

        send(2'b10, 9'h123, 1'b1, 1'b1, 6, 1'b0, t);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_strobe && cim_a == 4'd5) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_col5", seen, 1);
        rst = 1'b1;
        m_epol = 1'b0; m_eact = 1'b0;
        @(negedge clk);
        chk("midrst_outs", all_outs(), 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_queue", exp_q.size(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", cmd_ready, 1);
        send(2'b00, 9'h0AA, 1'b0, 1'b0, 0, 1'b1, t);
        cmd_valid = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
